// File: rtl/eth_phy_10g_pkg.sv
// Shared constants and types for the eth_phy_10g receive path: 66-bit block geometry,
// bitslip offset sizing, sync-header codes and a block bit-reversal helper.
package eth_phy_10g_pkg;

    localparam int BLOCK_WIDTH  = 66;
    localparam int OFFSET_WIDTH = 7;
    localparam int OFFSET_MAX   = 65;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    typedef logic [BLOCK_WIDTH-1:0]  block_t;
    typedef logic [OFFSET_WIDTH-1:0] offset_t;

    // Mirrors a block end-for-end, for SERDES that deliver the latest bit in position 0.
    function automatic block_t reverse_block(input block_t word);
        block_t flipped;
        for (int i = 0; i < BLOCK_WIDTH; i++) begin
            flipped[i] = word[BLOCK_WIDTH-1-i];
        end
        return flipped;
    endfunction

endpackage

// File: rtl/eth_phy_10g_bit_window_mux.sv
// Combinational selector picking 66 consecutive bits out of a 132-bit two-word window.
// Offsets beyond the last legal one fall back to offset 0 so no X can escape.
module eth_phy_10g_bit_window_mux
    import eth_phy_10g_pkg::*;
(
    input  logic [2*BLOCK_WIDTH-1:0] window,
    input  offset_t                  offset,
    output block_t                   sel
);

    always_comb begin
        sel = window[BLOCK_WIDTH-1:0];
        for (int i = 1; i <= OFFSET_MAX; i++) begin
            if (offset == OFFSET_WIDTH'(i)) begin
                sel = window[i +: BLOCK_WIDTH];
            end
        end
    end

endmodule

// File: rtl/eth_phy_10g_rx_bitslip_align.sv
// Re-frames the raw 66-bit SERDES stream at a bit offset that advances by one on each
// rising edge of the PHY bitslip request, so block lock can be reached without SERDES help.
module eth_phy_10g_rx_bitslip_align
    import eth_phy_10g_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int BIT_REVERSE = 0
) (
    input  logic                  rx_clk,
    input  logic                  rx_rst,
    input  logic [DATA_WIDTH-1:0] serdes_in_data,
    input  logic [HDR_WIDTH-1:0]  serdes_in_hdr,
    input  logic                  serdes_in_valid,
    input  logic                  serdes_rx_bitslip,
    output logic [DATA_WIDTH-1:0] serdes_rx_data,
    output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
    output logic                  serdes_rx_valid,
    output logic [6:0]            slip_offset,
    output logic                  slip_wrap
);

    block_t  word_in;
    block_t  word_fwd;
    block_t  prev_reg;
    block_t  aligned;
    block_t  out_word;
    offset_t offset;
    logic    bs_d;
    logic    slip;
    logic    at_max;
    logic    suppress;
    logic    valid_reg;
    logic    wrap_reg;

    assign word_in  = {serdes_in_data, serdes_in_hdr};
    assign word_fwd = (BIT_REVERSE != 0) ? reverse_block(word_in) : word_in;

    eth_phy_10g_bit_window_mux u_window_mux (
        .window ({word_fwd, prev_reg}),
        .offset (offset),
        .sel    (aligned)
    );

    assign slip   = serdes_rx_bitslip & ~bs_d;
    assign at_max = (offset == OFFSET_WIDTH'(OFFSET_MAX));

    // The word arriving with a slip still uses the old offset; after a 65->0 wrap the next
    // valid output would repeat 65 bits of the previous one, so its valid is withheld.
    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            offset    <= '0;
            prev_reg  <= '0;
            out_word  <= '0;
            bs_d      <= 1'b0;
            valid_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            suppress  <= 1'b0;
        end else begin
            bs_d      <= serdes_rx_bitslip;
            wrap_reg  <= slip & at_max;
            valid_reg <= 1'b0;

            if (serdes_in_valid) begin
                out_word  <= (BIT_REVERSE != 0) ? reverse_block(aligned) : aligned;
                prev_reg  <= word_fwd;
                valid_reg <= ~suppress;
            end

            if (slip) begin
                offset <= at_max ? '0 : offset + 1'b1;
            end

            if (slip & at_max) begin
                suppress <= 1'b1;
            end else if (serdes_in_valid) begin
                suppress <= 1'b0;
            end
        end
    end

    assign serdes_rx_data  = out_word[BLOCK_WIDTH-1:HDR_WIDTH];
    assign serdes_rx_hdr   = out_word[HDR_WIDTH-1:0];
    assign serdes_rx_valid = valid_reg;
    assign slip_offset     = offset;
    assign slip_wrap       = wrap_reg;

endmodule

// File: tb/tb_eth_phy_10g_rx_bitslip_align.sv
// Self-checking bench: drives random and directed streams and compares every cycle against
// a bit-stream reference model (output k = stream bits starting at k*66 + offset).
module tb_eth_phy_10g_rx_bitslip_align;
    import eth_phy_10g_pkg::*;

    logic        clk = 1'b0;
    logic        rx_rst;
    logic [63:0] in_data;
    logic [1:0]  in_hdr;
    logic        in_valid;
    logic        bitslip;
    logic [63:0] rx_data;
    logic [1:0]  rx_hdr;
    logic        rx_valid;
    logic [6:0]  offset_obs;
    logic        wrap_obs;

    always #5 clk = ~clk;

    eth_phy_10g_rx_bitslip_align dut (
        .rx_clk            (clk),
        .rx_rst            (rx_rst),
        .serdes_in_data    (in_data),
        .serdes_in_hdr     (in_hdr),
        .serdes_in_valid   (in_valid),
        .serdes_rx_bitslip (bitslip),
        .serdes_rx_data    (rx_data),
        .serdes_rx_hdr     (rx_hdr),
        .serdes_rx_valid   (rx_valid),
        .slip_offset       (offset_obs),
        .slip_wrap         (wrap_obs)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a received-bit stream preceded by one all-zero word
    bit          stream_q[$];
    int          m_offset;
    bit          m_bs_prev;
    bit          m_suppress;
    bit          m_valid;
    bit          m_wrap;
    logic [65:0] m_word;

    localparam logic [65:0] IDLE_BLOCK = {64'h0707070707070707, 2'b01};

    task automatic checkOutput(input string tag, input logic [65:0] observed,
                               input logic [65:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic model_reset();
        stream_q.delete();
        repeat (66) stream_q.push_back(1'b0);
        m_offset   = 0;
        m_bs_prev  = 1'b0;
        m_suppress = 1'b0;
        m_valid    = 1'b0;
        m_wrap     = 1'b0;
        m_word     = '0;
    endtask

    task automatic model_step(input bit r, input bit v, input logic [65:0] w, input bit b);
        bit slip;
        if (r) begin
            model_reset();
            return;
        end
        slip      = b && !m_bs_prev;
        m_bs_prev = b;
        m_wrap    = slip && (m_offset == OFFSET_MAX);
        m_valid   = 1'b0;
        if (v) begin
            for (int i = 0; i < 66; i++) stream_q.push_back(w[i]);
            for (int i = 0; i < 66; i++) m_word[i] = stream_q[m_offset + i];
            repeat (66) void'(stream_q.pop_front());
            m_valid    = !m_suppress;
            m_suppress = 1'b0;
        end
        if (slip) begin
            if (m_offset == OFFSET_MAX) begin
                m_offset   = 0;
                m_suppress = 1'b1;
            end else begin
                m_offset++;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [65:0] w, input bit b);
        rx_rst            = r;
        in_valid          = v;
        {in_data, in_hdr} = w;
        bitslip           = b;
        @(posedge clk);
        model_step(r, v, w, b);
        #1;
        checkOutput("offset", 66'(offset_obs), 66'(m_offset));
        checkOutput("valid",  66'(rx_valid),   66'(m_valid));
        checkOutput("wrap",   66'(wrap_obs),   66'(m_wrap));
        checkOutput("word",   {rx_data, rx_hdr}, m_word);
    endtask

    function automatic logic [65:0] rand_word();
        return {$urandom(), $urandom(), 2'($urandom_range(0, 3))};
    endfunction

    initial begin
        bit          src_q[$];
        logic [65:0] w;
        int          wrap_count;
        int          supp_count;

        rx_rst   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_hdr   = '0;
        bitslip  = 1'b0;
        model_reset();

        // Reset state
        applyStimulus(1, 0, '0, 0);
        applyStimulus(1, 0, '0, 0);
        checkOutput("reset_offset", 66'(offset_obs), 66'd0);
        checkOutput("reset_word", {rx_data, rx_hdr}, 66'd0);

        // Aligned idle stream, no slips, with random idle gaps
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, ($urandom_range(0, 3) != 0), IDLE_BLOCK, 0);
        end
        checkOutput("aligned_word", {rx_data, rx_hdr}, IDLE_BLOCK);

        // Stream offset by 3 junk bits, recovered by 3 slip pulses
        applyStimulus(1, 0, '0, 0);
        repeat (3) src_q.push_back(bit'($urandom_range(0, 1)));
        repeat (21) for (int i = 0; i < 66; i++) src_q.push_back(IDLE_BLOCK[i]);
        for (int p = 0; p < 3; p++) begin
            applyStimulus(0, 0, '0, 1);
            applyStimulus(0, 0, '0, 0);
        end
        checkOutput("shift3_offset", 66'(offset_obs), 66'd3);
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 66; i++) w[i] = src_q.pop_front();
            applyStimulus(0, 1, w, 0);
            if (k >= 1) begin
                checkOutput("shift3_hdr",  66'(rx_hdr),  66'(SYNC_CTRL));
                checkOutput("shift3_data", 66'(rx_data), 66'(64'h0707070707070707));
            end
        end

        // Bitslip held high for 10 cycles counts once
        applyStimulus(1, 0, '0, 0);
        repeat (10) applyStimulus(0, 1, rand_word(), 1);
        applyStimulus(0, 1, rand_word(), 0);
        checkOutput("hold_once", 66'(offset_obs), 66'd1);

        // 66 pulses 9 cycles apart: one wrap, one suppressed valid
        applyStimulus(1, 0, '0, 0);
        wrap_count = 0;
        supp_count = 0;
        for (int p = 0; p < 66; p++) begin
            applyStimulus(0, 1, rand_word(), 1);
            wrap_count += int'(wrap_obs);
            supp_count += int'(!rx_valid);
            repeat (8) begin
                applyStimulus(0, 1, rand_word(), 0);
                wrap_count += int'(wrap_obs);
                supp_count += int'(!rx_valid);
            end
        end
        checkOutput("wrap_offset", 66'(offset_obs), 66'd0);
        checkOutput("wrap_count",  66'(wrap_count), 66'd1);
        checkOutput("supp_count",  66'(supp_count), 66'd1);

        // Reset mid-stream at offset 40
        applyStimulus(1, 0, '0, 0);
        for (int p = 0; p < 40; p++) begin
            applyStimulus(0, 1, rand_word(), 1);
            applyStimulus(0, ($urandom_range(0, 1) != 0), rand_word(), 0);
        end
        checkOutput("pre_reset_offset", 66'(offset_obs), 66'd40);
        repeat (3) applyStimulus(0, 1, rand_word(), 0);
        applyStimulus(1, 1, rand_word(), 1);
        checkOutput("midreset_offset", 66'(offset_obs), 66'd0);
        checkOutput("midreset_valid",  66'(rx_valid),   66'd0);
        checkOutput("midreset_word",   {rx_data, rx_hdr}, 66'd0);
        repeat (5) applyStimulus(0, 1, rand_word(), 0);

        // Random stress: random valid, slip toggles and occasional resets
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
                          rand_word(), ($urandom_range(0, 2) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: observed running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
